// File: rtl/systolic_pkg.sv
// Shared constants and FSM state type for the systolic array result drain.
package systolic_pkg;

   localparam int D_W_ACC_DFLT = 32;
   localparam int N1_DFLT      = 8;
   localparam int N2_DFLT      = 4;
   localparam int FIFO_D_DFLT  = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head. A push while full is accepted only
// when the same cycle pops, so the slot being freed is reused.
module sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; the head is only observed while the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/systolic_drain.sv
// Serializes per-row accumulator results into one row-major stream per tile.
// Define DRAIN_RELU_EN to clamp negative results to zero on m_data.
//
// state | meaning
// IDLE  | no tile in progress, row/col at 0, waiting for row 0 data
// DRAIN | tile in progress, row/col point at the next element to emit
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int D_W_ACC = D_W_ACC_DFLT,
   parameter int N1      = N1_DFLT,
   parameter int N2      = N2_DFLT,
   parameter int FIFO_D  = FIFO_D_DFLT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [D_W_ACC-1:0]  D [N1],
   input  logic [N1-1:0]              valid_D,
   output logic signed [D_W_ACC-1:0]  m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [$clog2(N1)-1:0]      m_row,
   output logic                       m_last,
   output logic                       overflow,
   output logic                       busy
);

   localparam int RW = (N1 > 1) ? $clog2(N1) : 1;
   localparam int CW = (N2 > 1) ? $clog2(N2) : 1;

   drain_state_t       state, state_nxt;
   logic [RW-1:0]      row, row_nxt;
   logic [CW-1:0]      col, col_nxt;
   logic [N1-1:0]      pop, full, empty;
   logic [D_W_ACC-1:0] dout [N1];
   logic [D_W_ACC-1:0] head, data_sel;
   logic               xfer, row_end, col_end, tile_end;

   for (genvar g = 0; g < N1; g++) begin : g_row
      sync_fifo #(
         .W     (D_W_ACC),
         .DEPTH (FIFO_D)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (valid_D[g]),
         .pop   (pop[g]),
         .din   (D[g]),
         .dout  (dout[g]),
         .full  (full[g]),
         .empty (empty[g])
      );
   end

   // The output path does not wait for the FSM, so a fresh tile is visible
   // the cycle after its first row 0 push.
   assign head     = dout[row];
   assign m_valid  = !empty[row];
   assign xfer     = m_valid && m_ready;
   assign row_end  = (row == RW'(N1 - 1));
   assign col_end  = (col == CW'(N2 - 1));
   assign tile_end = row_end && col_end;
   assign pop      = xfer ? (N1'(1) << row) : '0;

`ifdef DRAIN_RELU_EN
   assign data_sel = head[D_W_ACC-1] ? '0 : head;
`else
   assign data_sel = head;
`endif

   assign m_data = m_valid ? data_sel : '0;
   assign m_row  = row;
   assign m_last = m_valid && tile_end;
   assign busy   = (|(~empty)) || (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         row      <= '0;
         col      <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         row      <= row_nxt;
         col      <= col_nxt;
         overflow <= overflow | (|(valid_D & full & ~pop));
      end
   end

   always_comb begin
      state_nxt = state;
      row_nxt   = row;
      col_nxt   = col;
      if (xfer) begin
         if (col_end) begin
            col_nxt = '0;
            row_nxt = row_end ? '0 : row + RW'(1);
         end else begin
            col_nxt = col + CW'(1);
         end
      end
      case (state)
         IDLE:    if (!empty[0] && !(xfer && tile_end)) state_nxt = DRAIN;
         DRAIN:   if (xfer && tile_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule
